// File: rtl/vector_load_writeback_unit_pkg.sv
// Shared types and sizes for the vector load writeback path.
// Also used by the register file arbiter, which consumes wb_req_t.
package vector_load_writeback_unit_pkg;

  localparam int MAX_ELEMS      = 64;
  localparam int ELEM_WIDTH     = 64;
  localparam int ID_WIDTH       = 6;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } wb_state_e;

  // "reg" is a keyword, so the register index field is reg_addr.
  typedef struct packed {
    logic                      vld;
    logic [REG_ADDR_WIDTH-1:0] reg_addr;
    logic [ID_WIDTH-1:0]       elem;
    logic [ELEM_WIDTH-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/vlwb_elem_buffer.sv
// Element buffer: DEPTH x WIDTH storage with a per-entry valid bitmap.
// One write port (sets valid), one read port, one valid-clear port, bulk clear.
module vlwb_elem_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_all,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [WIDTH-1:0] set_data,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [DEPTH-1:0] valid_bits
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; the valid bitmap alone decides
  // whether an entry holds live data, so clearing it is enough.
  always_ff @(posedge clk) begin
    if (set_en) mem[set_idx] <= set_data;
  end

  // A set and a clear of the same index in one cycle leaves the entry valid:
  // the later assignment wins, matching the fresh data just written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_bits <= '0;
    end else if (clear_all) begin
      valid_bits <= '0;
    end else begin
      if (clr_en) valid_bits[clr_idx] <= 1'b0;
      if (set_en) valid_bits[set_idx] <= 1'b1;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/vector_load_writeback_unit.sv
// Collects out-of-order load responses and writes them to one vector register
// in element order. Optional response checking: define VLWB_ERR_CHECK_EN.
module vector_load_writeback_unit #(
  parameter int MAX_ELEMS      = vector_load_writeback_unit_pkg::MAX_ELEMS,
  parameter int ELEM_WIDTH     = vector_load_writeback_unit_pkg::ELEM_WIDTH,
  parameter int ID_WIDTH       = vector_load_writeback_unit_pkg::ID_WIDTH,
  parameter int REG_ADDR_WIDTH = vector_load_writeback_unit_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_vld,
  input  logic [REG_ADDR_WIDTH-1:0] start_dest,
  input  logic [ID_WIDTH:0]         start_length,
  output logic                      busy,
  output logic                      done,
  input  logic                      rsp_vld,
  input  logic [ID_WIDTH-1:0]       rsp_id,
  input  logic [ELEM_WIDTH-1:0]     rsp_data,
  output logic                      rsp_rcvd,
  output logic                      wr_vld,
  output logic [REG_ADDR_WIDTH-1:0] wr_reg,
  output logic [ID_WIDTH-1:0]       wr_elem,
  output logic [ELEM_WIDTH-1:0]     wr_data,
  input  logic                      wr_grant,
  output logic                      error
);

  import vector_load_writeback_unit_pkg::*;

  wb_state_e                 state, state_nxt;
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  logic [ID_WIDTH:0]         length_q;
  logic [ID_WIDTH:0]         next_elem_q;
  logic [ID_WIDTH:0]         next_elem_inc;
  logic [MAX_ELEMS-1:0]      valid_bits;
  logic [ELEM_WIDTH-1:0]     rd_data;
  logic [ID_WIDTH-1:0]       rd_idx;
  logic                      start_acc;
  logic                      rsp_acc;
  logic                      buf_we;
  logic                      grant;
  logic                      last_grant;
  wb_req_t                   req;

  assign start_acc     = (state == IDLE) && start_vld;
  assign rsp_acc       = (state == COLLECT) && rsp_vld;
  assign rsp_rcvd      = rsp_acc;
  assign rd_idx        = next_elem_q[ID_WIDTH-1:0];
  assign next_elem_inc = next_elem_q + {{ID_WIDTH{1'b0}}, 1'b1};
  assign grant         = req.vld && wr_grant;
  assign last_grant    = grant && (next_elem_inc == length_q);

`ifdef VLWB_ERR_CHECK_EN
  logic rsp_bad;
  logic error_q;

  // Out-of-range or duplicate responses are acknowledged but never stored.
  assign rsp_bad = ({1'b0, rsp_id} >= length_q) || valid_bits[rsp_id];
  assign buf_we  = rsp_acc && !rsp_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                error_q <= 1'b0;
    else if (start_acc)        error_q <= 1'b0;
    else if (rsp_acc && rsp_bad) error_q <= 1'b1;
  end

  assign error = error_q;
`else
  assign buf_we = rsp_acc;
  assign error  = 1'b0;
`endif

  vlwb_elem_buffer #(
    .DEPTH (MAX_ELEMS),
    .WIDTH (ELEM_WIDTH),
    .IDX_W (ID_WIDTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .clear_all  (start_acc),
    .set_en     (buf_we),
    .set_idx    (rsp_id),
    .set_data   (rsp_data),
    .clr_en     (grant),
    .clr_idx    (rd_idx),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .valid_bits (valid_bits)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_vld) state_nxt = (start_length == '0) ? DONE : COLLECT;
      COLLECT: if (last_grant) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The write request is derived from the bitmap and held until granted;
  // outputs read as zero whenever no write is offered.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    req  = '0;
    if ((state == COLLECT) && valid_bits[rd_idx]) begin
      req.vld      = 1'b1;
      req.reg_addr = dest_q;
      req.elem     = rd_idx;
      req.data     = rd_data;
    end
  end

  assign wr_vld  = req.vld;
  assign wr_reg  = req.reg_addr;
  assign wr_elem = req.elem;
  assign wr_data = req.data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dest_q      <= '0;
      length_q    <= '0;
      next_elem_q <= '0;
    end else if (start_acc) begin
      dest_q      <= start_dest;
      length_q    <= start_length;
      next_elem_q <= '0;
    end else if (grant) begin
      next_elem_q <= next_elem_inc;
    end
  end

endmodule

// File: tb/tb_vector_load_writeback_unit.sv
// Randomized self-checking bench for vector_load_writeback_unit against a
// job-level reference model; honours VLWB_ERR_CHECK_EN when defined.
module tb_vector_load_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_vld;
  logic [4:0]  start_dest;
  logic [6:0]  start_length;
  logic        busy, done;
  logic        rsp_vld;
  logic [5:0]  rsp_id;
  logic [63:0] rsp_data;
  logic        rsp_rcvd;
  logic        wr_vld;
  logic [4:0]  wr_reg;
  logic [5:0]  wr_elem;
  logic [63:0] wr_data;
  logic        wr_grant;
  logic        error;

  always #5 clk = ~clk;

  vector_load_writeback_unit dut (
    .clk(clk), .reset(reset),
    .start_vld(start_vld), .start_dest(start_dest), .start_length(start_length),
    .busy(busy), .done(done),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_rcvd(rsp_rcvd),
    .wr_vld(wr_vld), .wr_reg(wr_reg), .wr_elem(wr_elem), .wr_data(wr_data),
    .wr_grant(wr_grant), .error(error)
  );

  int n_cmp = 0;
  int n_bad = 0;

`ifdef VLWB_ERR_CHECK_EN
  bit err_en = 1'b1;
`else
  bit err_en = 1'b0;
`endif

  // Reference model: job phase, destination, count, elements written so far,
  // and the set of elements that are held but not yet written.
  int          m_phase;  // 0 idle, 1 collecting, 2 completing
  int          m_dest, m_len, m_next;
  bit          m_have [64];
  logic [63:0] m_data [64];
  bit          m_err;

  // Sender queue and observation logs
  int          tx_id [$];
  logic [63:0] tx_dat [$];
  int          wr_elems [$];
  logic [63:0] wr_datas [$];
  int          wr_cyc [$];
  int          done_cyc [$];
  int          acc_cyc [64];
  int          first_vld;
  int          vld_cycles;

  task automatic model_reset();
    m_phase = 0; m_dest = 0; m_len = 0; m_next = 0; m_err = 0;
    foreach (m_have[i]) m_have[i] = 1'b0;
  endtask

  task automatic model_commit();
    bit g, dup, oob;
    int id;
    case (m_phase)
      0: if (start_vld) begin
        m_dest = int'(start_dest); m_len = int'(start_length); m_next = 0; m_err = 0;
        foreach (m_have[i]) m_have[i] = 1'b0;
        m_phase = (m_len == 0) ? 2 : 1;
      end
      1: begin
        g   = m_have[m_next] && wr_grant;
        id  = int'(rsp_id);
        dup = m_have[id];
        oob = (id >= m_len);
        if (g) begin m_have[m_next] = 1'b0; m_next++; end
        if (rsp_vld) begin
          if (err_en && (dup || oob)) m_err = 1'b1;
          else begin m_data[id] = rsp_data; m_have[id] = 1'b1; end
        end
        if (g && m_next == m_len) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic clear_logs();
    wr_elems.delete(); wr_datas.delete(); wr_cyc.delete(); done_cyc.delete();
    foreach (acc_cyc[i]) acc_cyc[i] = -1;
    first_vld = -1; vld_cycles = 0;
  endtask

  task automatic drive(input bit st, input int dest, input int len, input bit rand_grant);
    start_vld    = st;
    start_dest   = 5'(dest);
    start_length = 7'(len);
    rsp_vld      = (tx_id.size() > 0);
    rsp_id       = (tx_id.size() > 0) ? 6'(tx_id[0]) : 6'd0;
    rsp_data     = (tx_id.size() > 0) ? tx_dat[0] : 64'd0;
    wr_grant     = rand_grant ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Runs one job cycle by cycle, comparing every output against the model.
  // abort_writes > 0 returns right at the clock edge after that many writes.
  task automatic run_job(input string name, input int dest, input int len,
                         input bit rand_grant, input int abort_writes, input int budget);
    int          cyc = 0;
    bit          fin = 0, saw_done = 0, prev_wait = 0, e_busy, e_done, e_rcvd, e_vld;
    logic [4:0]  e_reg, p_reg;
    logic [5:0]  e_elem, p_elem;
    logic [63:0] e_data, p_data;
    clear_logs();
    drive(1'b1, dest, len, rand_grant);
    while (!fin) begin
      @(negedge clk);
      e_busy = (m_phase != 0);
      e_done = (m_phase == 2);
      e_rcvd = rsp_vld && (m_phase == 1);
      e_vld  = (m_phase == 1) && (m_next < 64) && m_have[m_next];
      e_reg  = e_vld ? 5'(m_dest) : 5'd0;
      e_elem = e_vld ? 6'(m_next) : 6'd0;
      e_data = e_vld ? m_data[m_next] : 64'd0;
      n_cmp += 8;
      if (busy !== e_busy) begin n_bad++; $display("FAIL %s c%0d busy got %b want %b", name, cyc, busy, e_busy); end
      if (done !== e_done) begin n_bad++; $display("FAIL %s c%0d done got %b want %b", name, cyc, done, e_done); end
      if (rsp_rcvd !== e_rcvd) begin n_bad++; $display("FAIL %s c%0d rsp_rcvd got %b want %b", name, cyc, rsp_rcvd, e_rcvd); end
      if (wr_vld !== e_vld) begin n_bad++; $display("FAIL %s c%0d wr_vld got %b want %b", name, cyc, wr_vld, e_vld); end
      if (wr_reg !== e_reg) begin n_bad++; $display("FAIL %s c%0d wr_reg got %0d want %0d", name, cyc, wr_reg, e_reg); end
      if (wr_elem !== e_elem) begin n_bad++; $display("FAIL %s c%0d wr_elem got %0d want %0d", name, cyc, wr_elem, e_elem); end
      if (wr_data !== e_data) begin n_bad++; $display("FAIL %s c%0d wr_data got %h want %h", name, cyc, wr_data, e_data); end
      if (error !== m_err) begin n_bad++; $display("FAIL %s c%0d error got %b want %b", name, cyc, error, m_err); end
      if (prev_wait) begin
        n_cmp++;
        if (wr_vld !== 1'b1 || wr_reg !== p_reg || wr_elem !== p_elem || wr_data !== p_data) begin
          n_bad++;
          $display("FAIL %s c%0d stall_hold got vld=%b elem=%0d data=%h want vld=1 elem=%0d data=%h",
                   name, cyc, wr_vld, wr_elem, wr_data, p_elem, p_data);
        end
      end
      prev_wait = (wr_vld === 1'b1) && !wr_grant;
      p_reg = wr_reg; p_elem = wr_elem; p_data = wr_data;
      if (wr_vld === 1'b1) begin
        vld_cycles++;
        if (first_vld < 0) first_vld = cyc;
        if (wr_grant) begin wr_elems.push_back(int'(wr_elem)); wr_datas.push_back(wr_data); wr_cyc.push_back(cyc); end
      end
      if (done === 1'b1) done_cyc.push_back(cyc);
      if (e_rcvd && acc_cyc[rsp_id] < 0) acc_cyc[rsp_id] = cyc;
      @(posedge clk);
      model_commit();
      if (e_rcvd) begin void'(tx_id.pop_front()); void'(tx_dat.pop_front()); end
      if (m_phase == 2) saw_done = 1;
      if (saw_done && m_phase == 0) fin = 1;
      if (abort_writes > 0 && wr_elems.size() >= abort_writes) fin = 1;
      cyc++;
      if (!fin && cyc >= budget) begin
        n_cmp++; n_bad++; fin = 1;
        $display("FAIL %s timeout got %0d cycles without completion want <%0d", name, cyc, budget);
      end
      if (!fin) begin #1; drive(1'b0, dest, len, rand_grant); end
    end
    if (abort_writes == 0) begin
      #1; tx_id.delete(); tx_dat.delete(); drive(1'b0, 0, 0, 1'b0); wr_grant = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start_vld = 0; start_dest = 0; start_length = 0;
    rsp_vld = 1'b1; rsp_id = 6'd0; rsp_data = 64'hdead; wr_grant = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, rsp_rcvd, wr_vld, wr_reg, wr_elem, error} !== '0 || wr_data !== '0) begin
      n_bad++;
      $display("FAIL reset_state got busy=%b done=%b rcvd=%b vld=%b reg=%0d elem=%0d data=%h err=%b want all 0",
               busy, done, rsp_rcvd, wr_vld, wr_reg, wr_elem, wr_data, error);
    end
    @(posedge clk); #1;
    reset = 1'b1; rsp_vld = 1'b0; wr_grant = 1'b0;
  endtask

  task automatic test_in_order();
    for (int i = 0; i < 8; i++) begin tx_id.push_back(i); tx_dat.push_back({$urandom, $urandom}); end
    run_job("in_order", 3, 8, 1'b0, 0, 100);
    n_cmp += 3;
    if (wr_elems.size() != 8) begin n_bad++; $display("FAIL in_order_count got %0d want 8", wr_elems.size()); end
    for (int i = 0; i < 8 && i < wr_cyc.size(); i++) begin
      n_cmp++;
      if (wr_elems[i] != i || wr_cyc[i] != i + 2) begin
        n_bad++; $display("FAIL in_order_w%0d got elem=%0d cyc=%0d want elem=%0d cyc=%0d", i, wr_elems[i], wr_cyc[i], i, i + 2);
      end
    end
    if (done_cyc.size() != 1 || done_cyc[0] != 10) begin
      n_bad++; $display("FAIL in_order_done got n=%0d want n=1 at cyc 10", done_cyc.size());
    end
    if (error !== 1'b0) begin n_bad++; $display("FAIL in_order_err got %b want 0", error); end
  endtask

  task automatic test_out_of_order();
    int ids [4] = '{3, 1, 2, 0};
    foreach (ids[i]) begin tx_id.push_back(ids[i]); tx_dat.push_back({$urandom, $urandom}); end
    run_job("out_of_order", 7, 4, 1'b0, 0, 100);
    n_cmp += 3;
    if (first_vld != 5 || acc_cyc[0] != 4) begin
      n_bad++; $display("FAIL ooo_first_write got vld@%0d id0@%0d want vld@5 id0@4", first_vld, acc_cyc[0]);
    end
    if (wr_elems.size() != 4) begin n_bad++; $display("FAIL ooo_count got %0d want 4", wr_elems.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (wr_elems[i] != i || wr_cyc[i] != 5 + i) begin
          n_bad++; $display("FAIL ooo_w%0d got elem=%0d cyc=%0d want elem=%0d cyc=%0d", i, wr_elems[i], wr_cyc[i], i, 5 + i);
        end
      end
    end
    if (done_cyc.size() != 1 || done_cyc[0] != 9) begin
      n_bad++; $display("FAIL ooo_done got n=%0d want n=1 at cyc 9", done_cyc.size());
    end
  endtask

  task automatic test_random_64();
    int          order [64];
    logic [63:0] sent [64];
    int          j, t;
    foreach (order[i]) order[i] = i;
    for (int i = 63; i > 0; i--) begin
      j = int'($urandom_range(0, i)); t = order[i]; order[i] = order[j]; order[j] = t;
    end
    foreach (order[i]) begin
      sent[order[i]] = {$urandom, $urandom};
      tx_id.push_back(order[i]); tx_dat.push_back(sent[order[i]]);
    end
    run_job("random_64", int'($urandom_range(0, 31)), 64, 1'b1, 0, 2000);
    n_cmp += 2;
    if (wr_elems.size() != 64) begin n_bad++; $display("FAIL rand64_count got %0d want 64", wr_elems.size()); end
    else begin
      for (int i = 0; i < 64; i++) begin
        n_cmp++;
        if (wr_elems[i] != i || wr_datas[i] !== sent[i]) begin
          n_bad++; $display("FAIL rand64_w%0d got elem=%0d data=%h want elem=%0d data=%h", i, wr_elems[i], wr_datas[i], i, sent[i]);
        end
      end
    end
    if (done_cyc.size() != 1) begin n_bad++; $display("FAIL rand64_done got %0d pulses want 1", done_cyc.size()); end
  endtask

  task automatic test_len_zero();
    run_job("len_zero", 9, 0, 1'b0, 0, 20);
    n_cmp += 2;
    if (done_cyc.size() != 1 || done_cyc[0] != 1) begin
      n_bad++; $display("FAIL len0_done got n=%0d want n=1 at cyc 1", done_cyc.size());
    end
    if (vld_cycles != 0) begin n_bad++; $display("FAIL len0_no_write got %0d wr_vld cycles want 0", vld_cycles); end
  endtask

  task automatic test_error_check();
    logic [63:0] d_first, d_second, want;
    d_first = {$urandom, $urandom};
    d_second = ~d_first;
    tx_id = '{5, 2, 2, 0, 1, 3};
    tx_dat = '{64'h5555, d_first, d_second, 64'h1000, 64'h1001, 64'h1003};
    run_job("err_check", 12, 4, 1'b0, 0, 100);
    want = err_en ? d_first : d_second;
    n_cmp += 2;
    if (wr_elems.size() != 4 || wr_datas.size() != 4 || wr_datas[2] !== want) begin
      n_bad++; $display("FAIL err_dup_data got n=%0d want 4 writes with elem2 data=%h", wr_elems.size(), want);
    end
    @(negedge clk);
    if (error !== err_en) begin n_bad++; $display("FAIL err_flag got %b want %b", error, err_en); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_job();
    for (int i = 0; i < 8; i++) begin tx_id.push_back(i); tx_dat.push_back({$urandom, $urandom}); end
    run_job("mid_job", 6, 8, 1'b0, 3, 100);
    #1;
    reset = 1'b0;
    tx_id.delete(); tx_dat.delete(); drive(1'b0, 0, 0, 1'b0);
    model_reset();
    #1;
    n_cmp++;
    if ({busy, done, wr_vld, wr_reg, wr_elem, error} !== '0 || wr_data !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs got busy=%b done=%b vld=%b reg=%0d elem=%0d data=%h err=%b want all 0",
               busy, done, wr_vld, wr_reg, wr_elem, wr_data, error);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_hold got busy=%b done=%b want 0 0", busy, done);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin tx_id.push_back(i); tx_dat.push_back({$urandom, $urandom}); end
    run_job("after_reset", 1, 2, 1'b0, 0, 100);
    n_cmp++;
    if (wr_elems.size() != 2 || done_cyc.size() != 1) begin
      n_bad++; $display("FAIL after_reset_job got writes=%0d dones=%0d want 2 1", wr_elems.size(), done_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_random_64();
    test_len_zero();
    test_error_check();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
